// File: rtl/nor_fanout_capture.sv
// nor_fanout_capture: launches a toggle into the NOR fan-out chain and
// timestamps the first matching edge on every branch. It then streams one
// delay record per branch and reports the branch-to-branch skew.

// Per-branch capture lane: 2-FF synchroniser, registered edge detect and
// first-arrival timestamp.
module nor_fanout_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             launch,
  input  logic             capture_en,
  input  logic             expect_lvl,
  input  logic [CNT_W-1:0] cnt,
  input  logic             branch_in,
  output logic             arr,
  output logic [CNT_W-1:0] delay
);
  logic [1:0] sync_q;
  logic       prev_q;
  logic       hit;

  // Synchronise the async branch and flag a !E -> E transition one cycle later.
  // The flag is suppressed on the launch edge so that a stale edge from the
  // previous polarity is never seen as an arrival.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      hit    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], branch_in};
      prev_q <= sync_q[1];
      hit    <= !launch && (sync_q[1] == expect_lvl) && (prev_q != expect_lvl);
    end
  end

  // Keep only the first arrival; later edges on this branch are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      arr   <= 1'b0;
      delay <= '0;
    end else if (launch) begin
      arr   <= 1'b0;
      delay <= '0;
    end else if (capture_en && hit && !arr) begin
      arr   <= 1'b1;
      delay <= cnt;
    end
  end
endmodule

module nor_fanout_capture #(
  parameter  int N_BRANCH = 4,
  parameter  int CNT_W    = 8,
  parameter  int TIMEOUT  = 100,
  localparam int IDX_W    = (N_BRANCH > 1) ? $clog2(N_BRANCH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                launch_out,
  input  logic [N_BRANCH-1:0] branch_in,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [IDX_W-1:0]    res_idx,
  output logic [CNT_W-1:0]    res_delay,
  output logic                res_timeout,
  output logic                done,
  output logic [CNT_W-1:0]    skew
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BRANCH - 1);

  logic [1:0]                     state;
  logic [CNT_W-1:0]               cnt;
  logic [N_BRANCH-1:0]            arr;
  logic [N_BRANCH-1:0][CNT_W-1:0] delay;
  logic [IDX_W-1:0]               nxt_idx;
  logic                           launch;
  logic [CNT_W-1:0]               skew_c;

  // The expected arrival level is always the current launch level: the chain
  // has an even inversion count and launch_out only changes at launch.
  assign launch  = (state == S_IDLE) && start;
  assign busy    = (state != S_IDLE);
  assign nxt_idx = res_idx + 1'b1;

  for (genvar g = 0; g < N_BRANCH; g++) begin : g_lane
    nor_fanout_lane #(.CNT_W(CNT_W)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .launch     (launch),
      .capture_en (state == S_WAIT),
      .expect_lvl (launch_out),
      .cnt        (cnt),
      .branch_in  (branch_in[g]),
      .arr        (arr[g]),
      .delay      (delay[g])
    );
  end

  // Skew = spread of delays over arrived branches, 0 unless two or more arrived.
  always_comb begin
    logic [CNT_W-1:0] d_max;
    logic [CNT_W-1:0] d_min;
    logic             seen;
    logic             multi;
    d_max = '0;
    d_min = '1;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N_BRANCH; i++) begin
      if (arr[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        if (delay[i] > d_max) d_max = delay[i];
        if (delay[i] < d_min) d_min = delay[i];
      end
    end
    skew_c = multi ? (d_max - d_min) : '0;
  end

  // Measurement sequencer: launch, wait for arrivals or timeout, stream records.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      launch_out  <= 1'b0;
      cnt         <= '0;
      res_valid   <= 1'b0;
      res_idx     <= '0;
      res_delay   <= '0;
      res_timeout <= 1'b0;
      done        <= 1'b0;
      skew        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            launch_out <= ~launch_out;
            cnt        <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          // arr is the registered flag set, so a full set exits one cycle
          // after the last capture; an arrival in the timeout cycle still lands.
          if ((&arr) || (cnt == CNT_LAST)) begin
            state   <= S_REPORT;
            res_idx <= '0;
          end
        end
        S_REPORT: begin
          if (!res_valid) begin
            res_valid   <= 1'b1;
            res_delay   <= arr[res_idx] ? delay[res_idx] : '0;
            res_timeout <= !arr[res_idx];
          end else if (res_ready) begin
            if (res_idx == IDX_LAST) begin
              res_valid <= 1'b0;
              done      <= 1'b1;
              skew      <= skew_c;
              state     <= S_DONE;
            end else begin
              res_idx     <= nxt_idx;
              res_delay   <= arr[nxt_idx] ? delay[nxt_idx] : '0;
              res_timeout <= !arr[nxt_idx];
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nor_fanout_capture.sv
// Randomised bench for nor_fanout_capture. Branch waveforms are described as
// toggle times relative to the launch edge; the reference model derives
// each branch's expected delay from that level sequence.
module tb_nor_fanout_capture;
  localparam int NB      = 4;
  localparam int CW      = 8;
  localparam int TIMEOUT = 100;
  localparam int IW      = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic          launch_out;
  logic [NB-1:0] branch_in;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [IW-1:0] res_idx;
  logic [CW-1:0] res_delay;
  logic          res_timeout;
  logic          done;
  logic [CW-1:0] skew;

  nor_fanout_capture #(.N_BRANCH(NB), .CNT_W(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .launch_out(launch_out),
    .branch_in(branch_in), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_idx(res_idx), .res_delay(res_delay),
    .res_timeout(res_timeout), .done(done), .skew(skew)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Environment state
  int          cyc = 0;
  int          tl = 1000;
  int          launch_cyc = 0;
  int          vcnt = 0;
  int          rdy_m = 0;
  logic        last_lo = 1'b0;
  logic        model_lo = 1'b0;
  logic [NB-1:0] lvl = '0;
  int          tog [NB][3];

  // Monitor state
  int          q_idx[$];
  int          q_dly[$];
  int          q_to[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          first_v = -1;
  int          last_acc = 0;
  int          skew_got = 0;
  bit          hold = 1'b0;
  bit          prev_done = 1'b0;
  logic [31:0] held = '0;

  // One clock: advance time-since-launch, drive branches and ready.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      last_lo = launch_out;
      tl      = 1000;
      lvl     = '0;
    end else begin
      if (launch_out !== last_lo) begin
        last_lo    = launch_out;
        tl         = 0;
        launch_cyc = cyc;
      end else if (tl < 1000) tl++;
      for (int i = 0; i < NB; i++)
        for (int k = 0; k < 3; k++)
          if (tog[i][k] == tl) lvl[i] = ~lvl[i];
      if (res_valid) vcnt++;
    end
    branch_in = lvl;
    case (rdy_m)
      0:       res_ready = 1'b1;
      1:       res_ready = (vcnt > 7) && (vcnt % 2 == 1);
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Collect accepted records, check hold stability, done and busy.
  always @(negedge clk) begin
    if (rst) begin
      hold      = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("busy_after_done", busy, 0);
      if (res_valid) begin
        if (first_v < 0) first_v = cyc;
        if (hold) chk("hold_stable", {res_idx, res_delay, res_timeout}, held);
        if (res_ready) begin
          q_idx.push_back(int'(res_idx));
          q_dly.push_back(int'(res_delay));
          q_to.push_back(int'(res_timeout));
          last_acc = cyc;
        end
      end
      hold = res_valid && !res_ready;
      held = 32'({res_idx, res_delay, res_timeout});
      if (done) begin
        done_cnt++;
        skew_got = int'(skew);
        done_cyc = cyc;
      end
      prev_done = done;
    end
  end

  // Expected delay: first cycle the branch level moves from !e to e, plus the
  // 3-cycle sync/detect latency, if that still lies within the timeout window.
  function automatic int model_delay(input int i, input logic e);
    logic lv;
    logic pv;
    lv = lvl[i];
    pv = lv;
    for (int t = 0; t < TIMEOUT; t++) begin
      for (int k = 0; k < 3; k++)
        if (tog[i][k] == t) lv = ~lv;
      if (lv == e && pv != e && t + 3 <= TIMEOUT - 1) return t + 3;
      pv = lv;
    end
    return -1;
  endfunction

  task automatic set_tog(input int i, input int a, input int b, input int c);
    tog[i][0] = a;
    tog[i][1] = b;
    tog[i][2] = c;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step();
    chk("rst_launch", launch_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_idx", res_idx, 0);
    chk("rst_delay", res_delay, 0);
    chk("rst_timeout", res_timeout, 0);
    chk("rst_done", done, 0);
    chk("rst_skew", skew, 0);
    rst      = 1'b0;
    model_lo = 1'b0;
  endtask

  task automatic run_meas(input int rm, input bit poke, input bit chk_lat);
    int   exp_d[NB];
    int   dmin;
    int   dmax;
    int   narr;
    logic e;
    while (tl < 64) step();
    step();
    rdy_m    = rm;
    e        = ~model_lo;
    model_lo = e;
    for (int i = 0; i < NB; i++) exp_d[i] = model_delay(i, e);
    q_idx.delete();
    q_dly.delete();
    q_to.delete();
    done_cnt = 0;
    first_v  = -1;
    vcnt     = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 600 && done_cnt == 0; k++) begin
      start = poke && (tl == 20 || vcnt == 2);
      step();
    end
    start = 1'b0;
    step();
    step();
    chk("done_once", done_cnt, 1);
    chk("launch_lvl", launch_out, model_lo);
    chk("n_rec", q_idx.size(), NB);
    dmin = 1 << 30;
    dmax = 0;
    narr = 0;
    for (int i = 0; i < NB; i++) begin
      if (exp_d[i] >= 0) begin
        narr++;
        if (exp_d[i] < dmin) dmin = exp_d[i];
        if (exp_d[i] > dmax) dmax = exp_d[i];
      end
      if (i < q_idx.size()) begin
        chk("rec_idx", q_idx[i], i);
        chk("rec_delay", q_dly[i], (exp_d[i] < 0) ? 0 : exp_d[i]);
        chk("rec_timeout", q_to[i], (exp_d[i] < 0) ? 1 : 0);
      end
    end
    chk("skew", skew_got, (narr >= 2) ? dmax - dmin : 0);
    if (rm == 0) begin
      chk("rec_back2back", last_acc - first_v, NB - 1);
      chk("done_lat", done_cyc - last_acc, 1);
    end
    if (chk_lat) chk("report_lat", first_v - launch_cyc, TIMEOUT + 1);
  endtask

  task automatic abort_run(input bit in_rep);
    while (tl < 64) step();
    step();
    rdy_m = 1;
    vcnt  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    if (!in_rep) begin
      repeat (6) step();
      chk("abort_busy_wait", busy, 1);
    end else begin
      for (int k = 0; k < 300 && !res_valid; k++) step();
      chk("abort_in_report", res_valid, 1);
    end
    do_rst();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got 0 exp 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d;
    int a;
    rst       = 1'b1;
    start     = 1'b0;
    res_ready = 1'b1;
    branch_in = '0;
    for (int i = 0; i < NB; i++) set_tog(i, -1, -1, -1);
    repeat (2) step();
    do_rst();

    // Loopback: branch i follows launch by 5+i cycles, twice back to back.
    for (int i = 0; i < NB; i++) set_tog(i, 5 + i, -1, -1);
    run_meas(0, 1'b0, 1'b0);
    run_meas(0, 1'b0, 1'b0);

    // Branch 2 stuck low, others at 5: timeout path.
    do_rst();
    for (int i = 0; i < NB; i++) set_tog(i, 5, -1, -1);
    set_tog(2, -1, -1, -1);
    run_meas(0, 1'b0, 1'b1);

    // Backpressure with random single-edge delays.
    do_rst();
    for (int i = 0; i < NB; i++) set_tog(i, int'($urandom_range(0, 45)), -1, -1);
    run_meas(1, 1'b0, 1'b0);

    // Glitch on branch 1 plus start pokes during WAIT and REPORT.
    set_tog(0, 30, -1, -1);
    set_tog(1, 4, 5, 12);
    set_tog(2, 10, -1, -1);
    set_tog(3, 20, -1, -1);
    run_meas(1, 1'b1, 1'b0);

    // Random mixes of single edges, glitches and dead branches.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NB; i++) begin
        case ($urandom_range(0, 5))
          0: set_tog(i, -1, -1, -1);
          1: begin
            a = int'($urandom_range(0, 20));
            set_tog(i, a, a + 1, int'($urandom_range(a + 3, 40)));
          end
          default: begin
            d = int'($urandom_range(0, 45));
            set_tog(i, d, -1, -1);
          end
        endcase
      end
      run_meas(int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    // Reset mid-WAIT and mid-REPORT, each followed by a clean measurement.
    for (int i = 0; i < NB; i++) set_tog(i, 5 + i, -1, -1);
    abort_run(1'b0);
    run_meas(0, 1'b0, 1'b0);
    abort_run(1'b1);
    run_meas(0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/nor_fanout_capture.md
# nor_fanout_capture

Synchronous launch-and-capture unit for the NOR fan-out delay experiment. It toggles the input of the NOR chain under test and timestamps the first matching transition on each of the N_BRANCH fan-out chain outputs, in clock cycles. It then streams one delay record per branch over a valid/ready port and reports the branch-to-branch skew. It sits on the measurement side of the fan-out chain: its launch output drives the chain input, and the chain's branch outputs return to its capture inputs.

## Interface
- N_BRANCH, 4, number of fan-out branch outputs captured
- CNT_W, 8, width of cycle counter and delay fields
- TIMEOUT, 100, cycles after launch before unarrived branches are declared timed out (1 ≤ TIMEOUT ≤ 2^CNT_W−1)
- IDX_W, $clog2(N_BRANCH), width of the branch index (derived)

- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- launch_out  out  1  drives the chain input; toggles once per measurement
- branch_in  in  N_BRANCH  chain branch outputs; asynchronous, each passed through an internal 2-FF synchroniser
- busy  out  1  high in every state except IDLE
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts the record
- res_idx  out  IDX_W  branch index of the record
- res_delay  out  CNT_W  cycles from launch to detected arrival; 0 when timed out
- res_timeout  out  1  branch did not arrive within TIMEOUT
- done  out  1  one-cycle pulse at end of measurement
- skew  out  CNT_W  max−min res_delay over arrived branches; valid while done is high

## Operation
- States: IDLE, WAIT, REPORT, DONE.
- IDLE + start: at that edge, launch_out toggles, expected level E is set to the new launch_out value, the counter is set to 0, and arrival flags are cleared. Next state is WAIT.
- The chain has an even inversion count (10 NOR stages), so a branch arrives when its synchronised value moves from !E to E. This is a true edge: the previous synchronised sample must be !E. A branch already at E, or stuck, is never recorded and times out.
- WAIT: the counter increments by 1 each cycle and saturates at 2^CNT_W−1.
  - On the first arrival of branch i, store delay[i] = the current counter value (the value before the increment) and set arr[i].
  - Later edges on branch i are ignored.
  - Simultaneous arrivals on several branches all record the same value.
- WAIT exits to REPORT when all arr bits are set, or when counter == TIMEOUT−1, whichever comes first. An arrival in the exit cycle is still recorded.
- REPORT: emit records for idx 0 .. N_BRANCH−1 in order.
  - res_valid is held high with stable fields until res_ready is sampled high.
  - A record advances on each cycle with res_valid && res_ready.
  - After idx N_BRANCH−1 is accepted, go to DONE.
- DONE: assert done for 1 cycle with skew. skew = 0 if fewer than 2 branches arrived. Then go to IDLE.
- start is ignored in every state except IDLE; there is no queueing.
- rst at any time: return to IDLE the next cycle, abandon any partial measurement, and flush the synchronisers to 0.

## Timing
- Reset values: launch_out=0, busy=0, res_valid=0, res_idx=0, res_delay=0, res_timeout=0, done=0, skew=0. Synchroniser flops=0. Counter and stored delays=0.
- Reported delay includes the 2-cycle synchroniser latency plus 1 edge-detect cycle. A branch that changes in the cycle immediately after the launch edge reports a delay of 3. The minimum reportable arrival is therefore 3.
- A timed-out branch reports res_delay=0 and res_timeout=1.
- First res_valid appears 1 cycle after entering REPORT.
- With res_ready tied high, records occupy N_BRANCH consecutive cycles, then done follows 1 cycle later.
- busy rises on the edge after start and falls in the cycle after done.
- launch_out alternates 0→1→0 across successive measurements and is never reset by completion, only by rst.

## Test plan
- Loopback model: branch i = launch_out delayed by 5+i cycles (async model), start pulse, res_ready=1. Expect records idx 0..3 with delays 8,9,10,11, timeout=0, and skew=3.
- Two back-to-back measurements: launch_out goes 1 then 0. Both report identical delays, and E tracks the toggle on each run.
- Branch 2 stuck at 0, others at delay 5: expect branch 2 res_timeout=1 and res_delay=0, with REPORT entered exactly TIMEOUT cycles after launch. Others report 8, and skew=0.
- Backpressure: hold res_ready low 7 cycles, then toggle it every other cycle. Each record is held stable while unaccepted; no record is lost or duplicated; done is high exactly once.
- Glitch on branch 1: pulse at 4 cycles and final edge at 12. Expect delay 7 for the first edge, with later edges ignored. Also, start asserted during WAIT/REPORT has no effect.
- rst asserted mid-WAIT and mid-REPORT: next cycle all outputs are at reset values and the state is IDLE. A new start then completes normally with launch_out 0→1.
